// File: rtl/game_defs_pkg.sv
// Encodings shared by the round controller and the LED/score decode,
// plus default tick lengths and the saturating score step.
package game_defs_pkg;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    B_IDLE  = 2'b00,
    B_FUSE  = 2'b01,
    B_BLAST = 2'b10,
    B_COOL  = 2'b11
  } bomb_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  localparam logic OWNER_P1 = 1'b0;
  localparam logic OWNER_P2 = 1'b1;

  localparam int SCORE_W          = 4;
  localparam int DEF_FUSE_TICKS   = 72;
  localparam int DEF_BLAST_TICKS  = 24;
  localparam int DEF_COOL_TICKS   = 8;
  localparam int DEF_PAUSE_TICKS  = 48;
  localparam int DEF_WIN_SCORE    = 10;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/bomb_round_controller_if.sv
// Player-side inputs and game/bomb outputs between the controller and the
// button/position + VGA logic.
interface bomb_round_controller_if #(parameter int COORD_W = 10);
  logic               p1_req, p2_req;
  logic [COORD_W-1:0] p1_x, p1_y, p2_x, p2_y;
  logic               p1_in_blast, p2_in_blast;
  logic [1:0]         state;
  logic [3:0]         p1_score, p2_score;
  logic [1:0]         winner;
  logic               bomb_active, bomb_blink, explode;
  logic [COORD_W-1:0] bomb_x, bomb_y;
  logic               bomb_owner, grant_p1, grant_p2;

  modport master (
    input  p1_req, p2_req, p1_x, p1_y, p2_x, p2_y, p1_in_blast, p2_in_blast,
    output state, p1_score, p2_score, winner, bomb_active, bomb_blink, explode,
           bomb_x, bomb_y, bomb_owner, grant_p1, grant_p2
  );

  modport slave (
    output p1_req, p2_req, p1_x, p1_y, p2_x, p2_y, p1_in_blast, p2_in_blast,
    input  state, p1_score, p2_score, winner, bomb_active, bomb_blink, explode,
           bomb_x, bomb_y, bomb_owner, grant_p1, grant_p2
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; a tie goes to whoever was not granted last.
module rr_arbiter2
  import game_defs_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == OWNER_P2) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  last_grant <= OWNER_P2;
    else if (|gnt) last_grant <= gnt[1];
  end
endmodule

// File: rtl/bomb_round_controller.sv
// Round sequencing for the two-player bomb game: owns the single bomb slot,
// its fuse/blast/cool timers, hit scoring and the round-over pause.
module bomb_round_controller
  import game_defs_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int FUSE_TICKS  = DEF_FUSE_TICKS,
  parameter int BLAST_TICKS = DEF_BLAST_TICKS,
  parameter int COOL_TICKS  = DEF_COOL_TICKS,
  parameter int PAUSE_TICKS = DEF_PAUSE_TICKS,
  parameter int WIN_SCORE   = DEF_WIN_SCORE
)(
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic start,
  bomb_round_controller_if.master bus
);
  localparam int MAX_A = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int MAX_B = (COOL_TICKS > PAUSE_TICKS) ? COOL_TICKS : PAUSE_TICKS;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_RAW = $clog2(MAX_T + 1);
  // at least 4 bits so the blink tap on bit 3 always exists
  localparam int CNT_W = (CNT_RAW < 4) ? 4 : CNT_RAW;
  localparam logic [CNT_W-1:0]   FUSE_LD  = CNT_W'(FUSE_TICKS - 1);
  localparam logic [CNT_W-1:0]   BLAST_LD = CNT_W'(BLAST_TICKS - 1);
  localparam logic [CNT_W-1:0]   COOL_LD  = CNT_W'(COOL_TICKS - 1);
  localparam logic [CNT_W-1:0]   PAUSE_LD = CNT_W'(PAUSE_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_LIM  = SCORE_W'(WIN_SCORE);

  game_state_e          gstate, gstate_nxt;
  bomb_state_e          bstate, bstate_nxt;
  winner_e              winner, winner_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, pause_cnt, pause_nxt;
  logic [SCORE_W-1:0]   s1, s1_nxt, s2, s2_nxt;
  logic                 h1, h1_nxt, h2, h2_nxt, h1_s, h2_s;
  logic [COORD_W-1:0]   bomb_x, bomb_y;
  logic                 bomb_owner, grant_p1, grant_p2;
  logic                 arb_en;
  logic [1:0]           gnt;

  // start is included so a tick that also drops start never fires a grant
  assign arb_en = tick && start && (gstate == QGAME_1) && (bstate == B_IDLE);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req     ({bus.p2_req, bus.p1_req}),
    .gnt     (gnt)
  );

  assign h1_s = h1 | bus.p1_in_blast;
  assign h2_s = h2 | bus.p2_in_blast;

  always_comb begin
    gstate_nxt = gstate;
    bstate_nxt = bstate;
    winner_nxt = winner;
    cnt_nxt    = cnt;
    pause_nxt  = pause_cnt;
    s1_nxt     = s1;
    s2_nxt     = s2;
    h1_nxt     = h1;
    h2_nxt     = h2;
    if (tick) begin
      if (!start) begin
        gstate_nxt = QI;
        bstate_nxt = B_IDLE;
      end else begin
        case (gstate)
          QI: begin
            gstate_nxt = QGAME_1;
            bstate_nxt = B_IDLE;
            s1_nxt     = '0;
            s2_nxt     = '0;
            winner_nxt = WIN_NONE;
          end
          QGAME_1: begin
            case (bstate)
              B_IDLE: if (|gnt) begin
                bstate_nxt = B_FUSE;
                cnt_nxt    = FUSE_LD;
              end
              B_FUSE: if (cnt == '0) begin
                bstate_nxt = B_BLAST;
                cnt_nxt    = BLAST_LD;
                h1_nxt     = 1'b0;
                h2_nxt     = 1'b0;
              end else cnt_nxt = cnt - 1'b1;
              B_BLAST: begin
                h1_nxt = h1_s;
                h2_nxt = h2_s;
                if (cnt == '0) begin
                  bstate_nxt = B_IDLE;
                  // exactly one player caught: the other one scores, whoever owns the bomb
                  if (h1_s ^ h2_s) begin
                    if (h2_s) s1_nxt = sat_inc(s1, WIN_LIM);
                    else      s2_nxt = sat_inc(s2, WIN_LIM);
                    if (s1_nxt == WIN_LIM || s2_nxt == WIN_LIM) begin
                      gstate_nxt = QDONE;
                      winner_nxt = h2_s ? WIN_P1 : WIN_P2;
                    end else begin
                      gstate_nxt = QGAME_2;
                      pause_nxt  = PAUSE_LD;
                    end
                  end else begin
                    bstate_nxt = B_COOL;
                    cnt_nxt    = COOL_LD;
                  end
                end else cnt_nxt = cnt - 1'b1;
              end
              default: if (cnt == '0) bstate_nxt = B_IDLE;
                       else           cnt_nxt    = cnt - 1'b1;
            endcase
          end
          QGAME_2: if (pause_cnt == '0) gstate_nxt = QGAME_1;
                   else                 pause_nxt  = pause_cnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gstate     <= QI;
      bstate     <= B_IDLE;
      winner     <= WIN_NONE;
      cnt        <= '0;
      pause_cnt  <= '0;
      s1         <= '0;
      s2         <= '0;
      h1         <= 1'b0;
      h2         <= 1'b0;
      bomb_x     <= '0;
      bomb_y     <= '0;
      bomb_owner <= OWNER_P1;
      grant_p1   <= 1'b0;
      grant_p2   <= 1'b0;
    end else begin
      gstate    <= gstate_nxt;
      bstate    <= bstate_nxt;
      winner    <= winner_nxt;
      cnt       <= cnt_nxt;
      pause_cnt <= pause_nxt;
      s1        <= s1_nxt;
      s2        <= s2_nxt;
      h1        <= h1_nxt;
      h2        <= h2_nxt;
      grant_p1  <= gnt[0];
      grant_p2  <= gnt[1];
      if (|gnt) begin
        bomb_owner <= gnt[1] ? OWNER_P2 : OWNER_P1;
        bomb_x     <= gnt[1] ? bus.p2_x : bus.p1_x;
        bomb_y     <= gnt[1] ? bus.p2_y : bus.p1_y;
      end
    end
  end

  assign bus.state       = gstate;
  assign bus.p1_score    = s1;
  assign bus.p2_score    = s2;
  assign bus.winner      = winner;
  assign bus.bomb_active = (bstate == B_FUSE);
  assign bus.bomb_blink  = (bstate == B_FUSE) && !cnt[3];
  assign bus.explode     = (bstate == B_BLAST);
  assign bus.bomb_x      = bomb_x;
  assign bus.bomb_y      = bomb_y;
  assign bus.bomb_owner  = bomb_owner;
  assign bus.grant_p1    = grant_p1;
  assign bus.grant_p2    = grant_p2;
endmodule
